// File: rtl/transport_tx_arbiter_pkg.sv
// transport_tx_arbiter_pkg: shared transport header bytes, tx state encoding and packet kind.
package transport_tx_arbiter_pkg;

    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;
    localparam logic [7:0] PAD_BYTE  = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CTRL_HI,
        CTRL_LO,
        AUD_HI,
        AUD_LO,
        PAD
    } tx_state_t;

    typedef enum logic {
        KIND_CTRL,
        KIND_AUDIO
    } pkt_kind_t;

endpackage

// File: rtl/transport_tx_arbiter_framer.sv
// transport_tx_framer: packet state sequencing, byte counter and audio slot counter.
module transport_tx_framer
    import transport_tx_arbiter_pkg::*;
#(
    parameter int PACKET_SIZE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_grant,
    input  logic       i_is_audio,
    input  logic       i_strobe,
    output logic [2:0] o_state
);

    localparam int SLOTS = (PACKET_SIZE - 1) / 2;
    localparam int BCW   = $clog2(PACKET_SIZE + 1);
    localparam int SCW   = $clog2(SLOTS + 1);

    tx_state_t        r_state, w_next;
    logic [BCW-1:0]   r_bytes;
    logic [SCW-1:0]   r_slots;
    logic             w_last_byte, w_last_slot;

    assign w_last_byte = r_bytes == BCW'(PACKET_SIZE - 1);
    assign w_last_slot = r_slots == SCW'(SLOTS - 1);
    assign o_state     = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_grant ? HDR : IDLE;
            HDR:     if (i_strobe) w_next = i_is_audio ? AUD_HI : CTRL_HI;
            CTRL_HI: if (i_strobe) w_next = CTRL_LO;
            CTRL_LO: if (i_strobe) w_next = PAD;
            AUD_HI:  if (i_strobe) w_next = AUD_LO;
            AUD_LO:  if (i_strobe) w_next = !w_last_slot ? AUD_HI : (w_last_byte ? IDLE : PAD);
            PAD:     if (i_strobe && w_last_byte) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_bytes <= '0;
            r_slots <= '0;
        end else begin
            r_state <= w_next;
            r_bytes <= (w_next == IDLE) ? '0 : (i_strobe ? r_bytes + BCW'(1) : r_bytes);
            r_slots <= (w_next == IDLE) ? '0 :
                       ((i_strobe && r_state == AUD_LO) ? r_slots + SCW'(1) : r_slots);
        end
    end

endmodule

// File: rtl/transport_tx_arbiter.sv
// transport_tx_arbiter: shares the network byte link between control and audio requesters.
// Optional audio fairness is enabled by defining TRANSPORT_TX_FAIRNESS_EN.
module transport_tx_arbiter
    import transport_tx_arbiter_pkg::*;
#(
    parameter int PACKET_SIZE    = 16,
    parameter int AUDIO_TIMEOUT  = 64,
    parameter int MAX_CTRL_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ctrlValid,
    input  logic [15:0] i_ctrlData,
    output logic        o_ctrlReady,
    input  logic        i_audioValid,
    input  logic [15:0] i_audioData,
    output logic        o_audioReady,
    input  logic        i_netBusy,
    output logic        o_sendSignal,
    output logic [7:0]  o_packetOut,
    output logic        o_txActive
);

    localparam int WW = $clog2(AUDIO_TIMEOUT + 1);

    tx_state_t      w_state;
    logic [2:0]     w_state_raw;
    pkt_kind_t      r_kind;
    logic [15:0]    r_data;
    logic [WW-1:0]  r_wait;
    logic [7:0]     r_last;
    logic [7:0]     w_byte;
    logic           w_avail, w_strobe, w_to, w_idle, w_aud_first;
    logic           w_grant_ctrl, w_grant_aud;

    transport_tx_framer #(.PACKET_SIZE(PACKET_SIZE)) u_framer (
        .clk        (clk),
        .reset      (reset),
        .i_grant    (w_grant_ctrl | w_grant_aud),
        .i_is_audio (r_kind == KIND_AUDIO),
        .i_strobe   (w_strobe),
        .o_state    (w_state_raw)
    );

    assign w_state      = tx_state_t'(w_state_raw);
    assign w_to         = r_wait == WW'(AUDIO_TIMEOUT);
    assign w_idle       = (w_state == IDLE) && reset;
    assign w_grant_ctrl = w_idle && i_ctrlValid && !w_aud_first;
    assign w_grant_aud  = w_idle && i_audioValid && !w_grant_ctrl;

`ifdef TRANSPORT_TX_FAIRNESS_EN
    localparam int BW = $clog2(MAX_CTRL_BURST + 1);
    logic [BW-1:0] r_burst;
    assign w_aud_first = i_audioValid && (r_burst >= BW'(MAX_CTRL_BURST));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_burst <= '0;
        else if (w_grant_aud)
            r_burst <= '0;
        else if (w_grant_ctrl && i_audioValid && r_burst < BW'(MAX_CTRL_BURST))
            r_burst <= r_burst + BW'(1);
    end
`else
    // Strict control priority; the burst limit is inert in this build.
    assign w_aud_first = MAX_CTRL_BURST < 0;
`endif

    always_comb begin
        w_byte  = PAD_BYTE;
        w_avail = 1'b1;
        case (w_state)
            IDLE:            w_avail = 1'b0;
            HDR:             w_byte  = (r_kind == KIND_CTRL) ? HDR_CTRL : HDR_AUDIO;
            CTRL_HI:         w_byte  = r_data[15:8];
            CTRL_LO, AUD_LO: w_byte  = r_data[7:0];
            AUD_HI: begin
                w_avail = i_audioValid || w_to;
                w_byte  = w_to ? PAD_BYTE : i_audioData[15:8];
            end
            default: ;
        endcase
    end

    assign w_strobe     = w_avail && !i_netBusy;
    assign o_sendSignal = w_strobe;
    assign o_packetOut  = w_strobe ? w_byte : r_last;
    assign o_ctrlReady  = w_grant_ctrl;
    assign o_audioReady = (w_state == AUD_HI) && i_audioValid && !w_to && !i_netBusy;
    assign o_txActive   = w_state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kind <= KIND_CTRL;
            r_data <= '0;
            r_wait <= '0;
            r_last <= '0;
        end else begin
            if (w_grant_ctrl | w_grant_aud) begin
                r_kind <= w_grant_ctrl ? KIND_CTRL : KIND_AUDIO;
                r_data <= i_ctrlData;
            end
            if (w_strobe)
                r_last <= w_byte;
            // Once timed out the low half of every remaining slot is padding too.
            if (w_state == AUD_HI && w_strobe)
                r_data <= w_to ? '0 : i_audioData;
            r_wait <= (w_state == IDLE || o_audioReady) ? '0 :
                      ((w_state == AUD_HI && !i_audioValid && !w_to) ? r_wait + WW'(1) : r_wait);
        end
    end

endmodule

// File: tb/tb_transport_tx_arbiter.sv
// tb_transport_tx_arbiter: directed checks of framing, arbitration, backpressure and timeout.
module tb_transport_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        netBusy = 1'b0;
    logic        ctrlReady, audioReady, sendSignal, txActive;
    logic [7:0]  packetOut;
    logic [15:0] ctrlData, audioData;
    logic        ctrlValid, audioValid;

    int ctrl_sent = 0, ctrl_first = 0, ctrl_lim = 0;
    int aud_sent = 0, aud_first = 0, aud_lim = 0;
    logic [15:0] ctrl_base = '0, aud_base = '0;
    int q[$];
    int tq[$];
    int cyc = 0;
    int total = 0, passes = 0;

    assign ctrlValid = ctrl_sent < ctrl_lim;
    assign ctrlData  = ctrl_base + 16'(ctrl_sent - ctrl_first);
    assign audioValid = aud_sent < aud_lim;
    assign audioData  = aud_base + 16'(aud_sent - aud_first);

    always #5 clk = ~clk;

    transport_tx_arbiter #(.PACKET_SIZE(16), .AUDIO_TIMEOUT(8), .MAX_CTRL_BURST(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_ctrlValid  (ctrlValid),
        .i_ctrlData   (ctrlData),
        .o_ctrlReady  (ctrlReady),
        .i_audioValid (audioValid),
        .i_audioData  (audioData),
        .o_audioReady (audioReady),
        .i_netBusy    (netBusy),
        .o_sendSignal (sendSignal),
        .o_packetOut  (packetOut),
        .o_txActive   (txActive)
    );

    // Requesters advance to their next word after each ready pulse.
    always @(negedge clk) if (ctrlReady) begin @(posedge clk); #1; ctrl_sent++; end
    always @(negedge clk) if (audioReady) begin @(posedge clk); #1; aud_sent++; end

    always @(negedge clk) begin
        cyc++;
        if (sendSignal) begin
            q.push_back(int'(packetOut));
            tq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget, output int used);
        used = 0;
        while (q.size() < n && used < budget) begin
            tick();
            used++;
        end
        if (q.size() < n) chk({tag, "_timeout"}, q.size(), n);
    endtask

    function automatic int aud_byte(input int i, input logic [15:0] base, input int ns);
        logic [15:0] s;
        int slot;
        slot = (i - 1) / 2;
        s = base + 16'(slot);
        if (i == 0) return 'h80;
        if (i == 15 || slot >= ns) return 0;
        return (i % 2 == 1) ? int'(s[15:8]) : int'(s[7:0]);
    endfunction

    initial begin
        int used;
        int a0;
        repeat (3) tick();
        chk("rst_send", int'(sendSignal), 0);
        chk("rst_pkt", int'(packetOut), 0);
        chk("rst_cready", int'(ctrlReady), 0);
        chk("rst_aready", int'(audioReady), 0);
        chk("rst_active", int'(txActive), 0);
        go();
        reset = 1'b1;
        tick();

        // Single control packet
        q.delete(); tq.delete();
        go();
        ctrl_base = 16'h1234; ctrl_first = ctrl_sent; ctrl_lim = ctrl_sent + 1;
        tick();
        chk("c_grant_ready", int'(ctrlReady), 1);
        chk("c_grant_nosend", int'(sendSignal), 0);
        wait_strobes("c", 16, 40, used);
        chk("c_cycles", used, 16);
        chk("c_b0", q[0], 'h40);
        chk("c_b1", q[1], 'h12);
        chk("c_b2", q[2], 'h34);
        for (int i = 3; i < 16; i++) chk($sformatf("c_pad%0d", i), q[i], 0);
        chk("c_active_last", int'(txActive), 1);
        tick();
        chk("c_len", q.size(), 16);
        chk("c_active_end", int'(txActive), 0);
        chk("c_readies", ctrl_sent - ctrl_first, 1);

        // Continuous audio packet
        q.delete(); tq.delete();
        go();
        aud_base = 16'h0101; aud_first = aud_sent; aud_lim = aud_sent + 7;
        wait_strobes("a", 16, 60, used);
        for (int i = 0; i < 16; i++) chk($sformatf("a_b%0d", i), q[i], aud_byte(i, 16'h0101, 7));
        tick();
        chk("a_len", q.size(), 16);
        chk("a_readies", aud_sent - aud_first, 7);
        chk("a_active_end", int'(txActive), 0);

        // Simultaneous requests: control first, one idle cycle, then audio
        q.delete(); tq.delete();
        go();
        ctrl_base = 16'hABCD; ctrl_first = ctrl_sent; ctrl_lim = ctrl_sent + 1;
        aud_base = 16'h0201; aud_first = aud_sent; aud_lim = aud_sent + 7;
        wait_strobes("both", 32, 80, used);
        chk("both_c_hdr", q[0], 'h40);
        chk("both_c_hi", q[1], 'hAB);
        chk("both_c_lo", q[2], 'hCD);
        chk("both_a_hdr", q[16], 'h80);
        chk("both_a_hi", q[17], 'h02);
        chk("both_a_lo", q[18], 'h01);
        chk("both_gap", tq[16] - tq[15], 2);
        tick();

        // Backpressure after the 4th byte
        q.delete(); tq.delete();
        go();
        aud_base = 16'h0301; aud_first = aud_sent; aud_lim = aud_sent + 7;
        wait_strobes("bp4", 4, 20, used);
        go();
        netBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_nosend%0d", i), int'(sendSignal), 0);
            chk($sformatf("bp_hold%0d", i), int'(packetOut), 'h03);
        end
        chk("bp_count", q.size(), 4);
        go();
        netBusy = 1'b0;
        wait_strobes("bp", 16, 60, used);
        for (int i = 0; i < 16; i++) chk($sformatf("bp_b%0d", i), q[i], aud_byte(i, 16'h0301, 7));
        tick();
        chk("bp_len", q.size(), 16);

        // Audio timeout after three samples
        q.delete(); tq.delete();
        go();
        aud_base = 16'h0401; aud_first = aud_sent; aud_lim = aud_sent + 3;
        wait_strobes("to", 16, 80, used);
        for (int i = 0; i < 16; i++) chk($sformatf("to_b%0d", i), q[i], aud_byte(i, 16'h0401, 3));
        chk("to_wait_gap", tq[7] - tq[6], 9);
        tick();
        chk("to_len", q.size(), 16);
        chk("to_readies", aud_sent - aud_first, 3);
        chk("to_active_end", int'(txActive), 0);

        // Both held: fairness decides the packet order
        q.delete(); tq.delete();
        go();
        ctrl_base = 16'h1000; ctrl_first = ctrl_sent; ctrl_lim = ctrl_sent + 100;
        aud_base = 16'h2000; aud_first = aud_sent; aud_lim = aud_sent + 100;
        a0 = aud_sent;
        wait_strobes("fair", 96, 300, used);
        go();
        ctrl_lim = ctrl_sent;
        aud_lim = aud_sent;
        repeat (3) tick();
        chk("fair_len", q.size(), 96);
        chk("fair_idle", int'(txActive), 0);
        for (int k = 0; k < 6; k++) begin
`ifdef TRANSPORT_TX_FAIRNESS_EN
            chk($sformatf("fair_hdr%0d", k), q[16 * k], (k % 3 == 2) ? 'h80 : 'h40);
`else
            chk($sformatf("fair_hdr%0d", k), q[16 * k], 'h40);
`endif
        end
`ifdef TRANSPORT_TX_FAIRNESS_EN
        chk("fair_aud_used", aud_sent - a0, 14);
`else
        chk("fair_aud_used", aud_sent - a0, 0);
`endif

        // Reset mid-packet abandons it
        q.delete(); tq.delete();
        go();
        ctrl_base = 16'h7777; ctrl_first = ctrl_sent; ctrl_lim = ctrl_sent + 1;
        wait_strobes("mr", 3, 20, used);
        go();
        reset = 1'b0;
        #1;
        chk("mr_send", int'(sendSignal), 0);
        chk("mr_active", int'(txActive), 0);
        chk("mr_pkt", int'(packetOut), 0);
        repeat (2) tick();
        chk("mr_len", q.size(), 3);
        go();
        reset = 1'b1;
        ctrl_base = 16'h8888; ctrl_first = ctrl_sent; ctrl_lim = ctrl_sent + 1;
        wait_strobes("mr2", 19, 60, used);
        chk("mr2_hdr", q[3], 'h40);
        chk("mr2_hi", q[4], 'h88);
        tick();
        chk("mr2_len", q.size(), 19);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
